// File: rtl/hb_decim2.sv
// 7-tap half-band decimate-by-2 FIR, h = [-1 0 9 16 9 0 -1]/32, shift-add datapath.
// state | meaning
// IDLE  | waiting for a trigger (every 2nd accepted sample)
// PRE   | symmetric pre-add of the delay line into p_a, p_b, c
// ACC1  | acc = 16*c + 9*p_b
// ACC2  | acc = acc - p_a
// OUT   | round, saturate and strobe the result
module hb_decim2 #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_WIDTH = 7
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clear,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         data_in_ready,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         data_out_ready,
  output logic                         overrun
);

  localparam int PW = DATA_WIDTH + 1;
  localparam int AW = DATA_WIDTH + 7;
  localparam logic signed [AW-1:0] OUT_MAX = AW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] OUT_MIN = AW'(-(2 ** (DATA_WIDTH - 1)));
  localparam logic signed [AW-1:0] RND_HALF = AW'(16);

  if (FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_frac
    $error("hb_decim2: FRAC_WIDTH must be smaller than DATA_WIDTH");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACC1, S_ACC2, S_OUT} state_t;

  state_t                  state_q, state_d;
  logic signed [DATA_WIDTH-1:0] x_q [7];
  logic signed [DATA_WIDTH-1:0] x_d [7];
  logic                    phase_q, phase_d;
  logic signed [PW-1:0]    pa_q, pa_d, pb_q, pb_d;
  logic signed [DATA_WIDTH-1:0] c_q, c_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                    dready_q, dready_d;
  logic                    ovr_q, ovr_d;
  logic                    trigger;
  logic signed [AW-1:0]    rnd, shf;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    phase_d  = phase_q;
    pa_d     = pa_q;
    pb_d     = pb_q;
    c_d      = c_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    dready_d = 1'b0;
    ovr_d    = ovr_q;
    trigger  = data_in_ready & phase_q;
    rnd      = acc_q + RND_HALF;
    shf      = rnd >>> 5;

    if (clear) begin
      state_d = S_IDLE;
      for (int k = 0; k < 7; k++) x_d[k] = '0;
      phase_d = 1'b0;
      pa_d    = '0;
      pb_d    = '0;
      c_d     = '0;
      acc_d   = '0;
      dout_d  = '0;
      ovr_d   = 1'b0;
    end else if (enable) begin
      // The delay line keeps moving even while a computation is in flight.
      if (data_in_ready) begin
        for (int k = 6; k > 0; k--) x_d[k] = x_q[k-1];
        x_d[0]  = data_in;
        phase_d = ~phase_q;
      end
      unique case (state_q)
        S_IDLE: if (trigger) state_d = S_PRE;
        S_PRE: begin
          pa_d    = PW'(x_q[0]) + PW'(x_q[6]);
          pb_d    = PW'(x_q[2]) + PW'(x_q[4]);
          c_d     = x_q[3];
          state_d = S_ACC1;
          if (trigger) ovr_d = 1'b1;
        end
        S_ACC1: begin
          acc_d   = (AW'(c_q) <<< 4) + (AW'(pb_q) <<< 3) + AW'(pb_q);
          state_d = S_ACC2;
          if (trigger) ovr_d = 1'b1;
        end
        S_ACC2: begin
          acc_d   = acc_q - AW'(pa_q);
          state_d = S_OUT;
          if (trigger) ovr_d = 1'b1;
        end
        S_OUT: begin
          if (shf > OUT_MAX)      dout_d = OUT_MAX[DATA_WIDTH-1:0];
          else if (shf < OUT_MIN) dout_d = OUT_MIN[DATA_WIDTH-1:0];
          else                    dout_d = shf[DATA_WIDTH-1:0];
          dready_d = 1'b1;
          state_d  = trigger ? S_PRE : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      for (int k = 0; k < 7; k++) x_q[k] <= '0;
      phase_q  <= 1'b0;
      pa_q     <= '0;
      pb_q     <= '0;
      c_q      <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
      dready_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      phase_q  <= phase_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      c_q      <= c_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
      dready_q <= dready_d;
      ovr_q    <= ovr_d;
    end
  end

  assign data_out       = dout_q;
  assign data_out_ready = dready_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_hb_decim2.sv
// Bench for hb_decim2: fixed vectors, hand-written corner sequences and random traffic
// checked against a sample-history reference model.
module tb_hb_decim2;

  logic clk = 1'b0;
  logic resetn, clear, enable, data_in_ready;
  logic signed [7:0] data_in;
  logic signed [7:0] data_out;
  logic data_out_ready, overrun;

  hb_decim2 #(.DATA_WIDTH(8), .FRAC_WIDTH(7)) dut (
    .clk(clk), .resetn(resetn), .clear(clear), .enable(enable),
    .data_in(data_in), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_ready(data_out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  int hist[7];
  bit phase_m;
  int n_en;
  int last_start;
  bit have_start;
  int due_q[$];
  int val_q[$];
  int dout_m;
  bit ovr_m;
  int cap[$];
  int strobes;

  typedef struct packed {
    logic [95:0] smp;
    logic [47:0] ex;
    logic [3:0]  n;
    logic [2:0]  ne;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fir_ref();
    int h[7];
    int sum, num, q;
    h = '{-1, 0, 9, 16, 9, 0, -1};
    sum = 0;
    for (int k = 0; k < 7; k++) sum += h[k] * hist[k];
    num = sum + 16;
    q = num / 32;
    if (num < 0 && (q * 32) != num) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 7; k++) hist[k] = 0;
    phase_m = 1'b0;
    have_start = 1'b0;
    due_q.delete();
    val_q.delete();
    dout_m = 0;
    ovr_m = 1'b0;
  endtask

  task automatic step(input bit en, input bit rdy, input int din, input bit clr);
    int exp_rdy;
    @(negedge clk);
    enable = en;
    data_in_ready = rdy;
    data_in = 8'(din);
    clear = clr;
    @(posedge clk);
    #1;
    exp_rdy = 0;
    if (clr) begin
      model_reset();
    end else if (en) begin
      n_en++;
      if (rdy) begin
        for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = din;
        if (phase_m) begin
          if (have_start && (n_en - last_start) < 4) begin
            ovr_m = 1'b1;
          end else begin
            have_start = 1'b1;
            last_start = n_en;
            due_q.push_back(n_en + 4);
            val_q.push_back(fir_ref());
          end
        end
        phase_m = ~phase_m;
      end
      if (due_q.size() > 0 && due_q[0] == n_en) begin
        void'(due_q.pop_front());
        dout_m = val_q.pop_front();
        exp_rdy = 1;
      end
    end
    check("data_out_ready", int'(data_out_ready), exp_rdy);
    check("data_out", int'(data_out), dout_m);
    check("overrun", int'(overrun), int'(ovr_m));
    if (data_out_ready) begin
      cap.push_back(int'(data_out));
      strobes++;
    end
  endtask

  initial begin
    int s_tab[5][12];
    int e_tab[5][6];
    int n_tab[5];
    int first_j;

    s_tab[0] = '{0, 32, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    e_tab[0] = '{-1, 9, 9, -1, 0, 0};
    n_tab[0] = 10;
    s_tab[1] = '{32, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    e_tab[1] = '{0, 16, 0, 0, 0, 0};
    n_tab[1] = 8;
    s_tab[2] = '{0, -128, 0, 127, 127, 127, 0, -128, 0, 0, 0, 0};
    e_tab[2] = '{4, -40, -4, 127, 0, 0};
    n_tab[2] = 8;
    s_tab[3] = '{0, 127, 0, -128, -128, -128, 0, 127, 0, 0, 0, 0};
    e_tab[3] = '{-4, 40, 4, -128, 0, 0};
    n_tab[3] = 8;
    s_tab[4] = '{64, 64, 64, 64, 64, 64, 64, 64, 64, 64, 64, 64};
    e_tab[4] = '{-2, 48, 66, 64, 64, 64};
    n_tab[4] = 12;
    for (int v = 0; v < 5; v++) begin
      vecs[v] = '0;
      vecs[v].n = 4'(n_tab[v]);
      vecs[v].ne = 3'(n_tab[v] / 2);
      for (int i = 0; i < 12; i++) vecs[v].smp[i*8 +: 8] = 8'(s_tab[v][i]);
      for (int i = 0; i < 6; i++) vecs[v].ex[i*8 +: 8] = 8'(e_tab[v][i]);
    end

    resetn = 1'b0;
    clear = 1'b0;
    enable = 1'b0;
    data_in_ready = 1'b0;
    data_in = '0;
    n_en = 0;
    strobes = 0;
    model_reset();
    #12;
    check("reset_data_out", int'(data_out), 0);
    check("reset_ready", int'(data_out_ready), 0);
    check("reset_overrun", int'(overrun), 0);
    resetn = 1'b1;

    // fixed vectors: one sample every 2 cycles after a clear
    for (int v = 0; v < 5; v++) begin
      step(1, 0, 0, 1);
      cap.delete();
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        step(1, 1, int'($signed(vecs[v].smp[i*8 +: 8])), 0);
        step(1, 0, 0, 0);
      end
      for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
      check($sformatf("vec%0d_count", v), cap.size(), int'(vecs[v].ne));
      for (int k = 0; k < int'(vecs[v].ne) && k < cap.size(); k++)
        check($sformatf("vec%0d_out%0d", v, k), cap[k], int'($signed(vecs[v].ex[k*8 +: 8])));
    end

    // back-to-back inputs: overrun on the 2nd trigger, strobes every 4 cycles
    step(1, 0, 0, 1);
    strobes = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1, 1, 50, 0);
      if (i == 3) check("ovr_before_2nd_trigger", int'(overrun), 0);
      if (i == 4) check("ovr_at_2nd_trigger", int'(overrun), 1);
    end
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    check("ovr_strobes", strobes, 3);
    check("ovr_sticky", int'(overrun), 1);

    // enable low for 3 cycles while in ACC1
    step(1, 0, 0, 1);
    strobes = 0;
    step(1, 1, 10, 0);
    step(1, 1, 20, 0);
    first_j = -1;
    for (int j = 1; j <= 10; j++) begin
      if (j >= 2 && j <= 4) step(0, 1, 99, 0);
      else step(1, 0, 0, 0);
      if (data_out_ready && first_j < 0) first_j = j;
    end
    check("en_latency", first_j, 7);
    check("en_value", int'(data_out), -1);
    check("en_strobes", strobes, 1);

    // clear while in ACC2 abandons the result; phase restarts at 0
    step(1, 0, 0, 1);
    strobes = 0;
    step(1, 1, 40, 0);
    step(1, 1, 40, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    check("clr_no_strobe", strobes, 0);
    cap.delete();
    step(1, 1, 32, 0);
    step(1, 0, 0, 0);
    step(1, 1, 64, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    check("clr_restart_strobes", strobes, 1);
    if (cap.size() > 0) check("clr_restart_value", cap[0], -2);
    else check("clr_restart_value_missing", 0, 1);

    // asynchronous reset while in PRE
    step(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 1, 50, 0);
    check("pre_rst_data_before", int'(data_out), 52);
    check("pre_rst_ovr_before", int'(overrun), 1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("async_rst_data_out", int'(data_out), 0);
    check("async_rst_ready", int'(data_out_ready), 0);
    check("async_rst_overrun", int'(overrun), 0);
    #2;
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

    // random traffic against the reference model
    step(1, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 255)) - 128, $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
